// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from the transmit FIFO and sends each as an 8N1 UART frame
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITWIDTH = 8,
  parameter int BIT_COUNTER_BITWIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tx_enable,
  input  logic                     fifo_read_ready,
  input  logic [DATA_BITWIDTH-1:0] fifo_read_data,
  output logic                     fifo_read_enable,
  output logic                     txd,
  output logic                     busy
);
  localparam int IW = DATA_BITWIDTH > 1 ? $clog2(DATA_BITWIDTH) : 1;
  localparam logic [BIT_COUNTER_BITWIDTH-1:0] CNT_LAST = BIT_COUNTER_BITWIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITWIDTH - 1);
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
  state_t r_state, w_next;
  logic [BIT_COUNTER_BITWIDTH-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [DATA_BITWIDTH-1:0] r_shift;
  logic w_bit_end;
  logic w_counting;
  assign w_bit_end = r_cnt == CNT_LAST;
  assign w_counting = r_state == START || r_state == DATA || r_state == STOP;
  assign busy = r_state != IDLE;
  // IDLE never pops, giving the FIFO's registered read a cycle to present the head byte
  always_comb begin
    w_next = r_state;
    fifo_read_enable = 1'b0;
    txd = 1'b1;
    case (r_state)
      IDLE: w_next = tx_enable && fifo_read_ready ? FETCH : IDLE;
      FETCH: begin
        fifo_read_enable = 1'b1;
        w_next = START;
      end
      START: begin
        txd = 1'b0;
        w_next = w_bit_end ? DATA : START;
      end
      DATA: begin
        txd = r_shift[0];
        w_next = w_bit_end && r_idx == IDX_LAST ? STOP : DATA;
      end
      STOP: w_next = w_bit_end ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_counting && !w_bit_end ? r_cnt + 1'b1 : '0;
      if (r_state == FETCH)
        r_shift <= fifo_read_data;
      else if (r_state == DATA && w_bit_end)
        r_shift <= r_shift >> 1;
      if (r_state == START)
        r_idx <= '0;
      else if (r_state == DATA && w_bit_end)
        r_idx <= r_idx + 1'b1;
    end
  end
endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Serial transmit stage directly downstream of the 8-bit BRAM-backed transmit FIFO.
- Pops one byte at a time through the FIFO read handshake (read_ready / read_enable / registered read_data).
- Serialises each byte as 8N1 UART (1 start bit, 8 data bits LSB first, 1 stop bit) on txd at a fixed clock-per-bit rate.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
- DATA_BITWIDTH, 8, byte width; equals the FIFO data width; frame carries DATA_BITWIDTH data bits.
- BIT_COUNTER_BITWIDTH, 10, width of the baud counter; must satisfy 2^BIT_COUNTER_BITWIDTH >= CLKS_PER_BIT.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- tx_enable  input  1  when high, new frames may start; when low, the current frame finishes and no new byte is popped.
- fifo_read_ready  input  1  FIFO non-empty.
- fifo_read_data  input  DATA_BITWIDTH  FIFO registered read data; valid one cycle after the read address settles.
- fifo_read_enable  output  1  one-cycle pop strobe to FIFO.
- txd  output  1  UART serial output, idle high.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, txd=1, fifo_read_enable=0, busy=0, baud counter=0, bit index=0, shift register=0. Takes effect immediately, including mid-frame; txd returns high without finishing the frame.
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE: txd=1.
  - If tx_enable & fifo_read_ready, go to FETCH next cycle.
  - No pop in IDLE; this gives the FIFO registered read one cycle to present the head byte.
- FETCH (exactly 1 cycle): txd=1.
  - fifo_read_enable=1 (Moore output, this cycle only).
  - Latch fifo_read_data into the shift register at the clock edge.
  - Clear baud counter; go to START.
- START: txd=0 for CLKS_PER_BIT cycles; then go to DATA with bit index=0.
- DATA: txd=shift_register[0].
  - Each time the baud counter reaches CLKS_PER_BIT-1: counter clears, shift register shifts right by 1, bit index increments.
  - After bit index DATA_BITWIDTH-1 completes, go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in START, DATA and STOP; wraps to 0 on each bit boundary.
  - Held at 0 in IDLE and FETCH.
- Latency: fifo_read_ready rising while idle → fifo_read_enable high 1 cycle later → txd falls 2 cycles after ready.
- Frame length: 1 FETCH cycle + (DATA_BITWIDTH+2)*CLKS_PER_BIT cycles.
- Back-to-back: with data continuously available, every frame is separated by exactly 2 high cycles (IDLE + FETCH) after the stop bit.
- fifo_read_enable is asserted at most once per frame and never while fifo_read_ready=0.
- Pointer settling: the pop's pointer increment settles well before the next FETCH (at least CLKS_PER_BIT cycles later), so fifo_read_data is always the correct head.
- tx_enable deasserted mid-frame: no effect on the current frame; the block stays in IDLE afterwards until tx_enable=1.
- fifo_read_ready dropping outside IDLE: ignored, since the byte is already latched.
- Empty FIFO: remain in IDLE, txd=1, busy=0.

Test Plan:
- CLKS_PER_BIT=4, reset, push 8'hA5, tx_enable=1 → single fifo_read_enable pulse; txd = 0 (4 cycles), then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles); busy high for 41 cycles.
- Push 8'h00, 8'hFF, 8'h3C back-to-back → three frames decoded correctly in order; exactly 2 idle-high cycles between each stop bit and the next start bit; exactly 3 pops.
- FIFO empty, tx_enable=1 for 100 cycles → txd=1, fifo_read_enable=0, busy=0 throughout.
- tx_enable=0 with 2 bytes queued → no pop. Raise tx_enable, drop it during the first frame's DATA state → first frame completes; second byte is not popped until tx_enable returns high.
- Assert reset_n=0 during DATA bit 3 of 8'h55 → txd=1 and busy=0 immediately (asynchronous). After release, the next queued byte transmits cleanly from START.
- CLKS_PER_BIT=868, send 8'h41 → each bit lasts exactly 868 cycles, measured by the bench's edge-to-edge timer.
